// File: rtl/sram_ctrl_if.sv
// Request/response handshake between a requester and sram_ctrl.
// The controller sits on the slave side; the requester uses master.
interface sram_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_ctrl.sv
// Synchronous initiator for an asynchronous single-port SRAM: one access at a time,
// sequenced as SETUP / STROBE (WAIT_CYCLES) / HOLD with registered, glitch-free strobes.
module sram_ctrl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_ctrl_if.slave            bus,
    output logic [ADDR_WIDTH-1:0] sram_address,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic                  sram_oe
);
    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic                  data_oe_q, data_oe_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  req_ready;
    logic                  accept;

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSetup;
                    write_d = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = '0;
            end
            StStrobe: begin
                if (cnt_q == CntLast) begin
                    state_d = StHold;
                    // SRAM output has had the whole strobe window to settle.
                    if (!write_q) rdata_d = sram_data;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Pin values are decoded from the next state so they come straight out of flops.
        cs_d        = (state_d != StIdle);
        we_d        = (state_d == StStrobe) && write_d;
        oe_d        = (state_d == StStrobe) && !write_d;
        data_oe_d   = cs_d && write_d;
        rsp_valid_d = (state_d == StHold) && !write_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            data_oe_q   <= data_oe_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign sram_address  = addr_q;
    assign sram_data     = data_oe_q ? wdata_q : 'z;
    assign sram_cs       = cs_q;
    assign sram_we       = we_q;
    assign sram_oe       = oe_q;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: W=1 instance driven through a read scoreboard and pin monitors,
// plus a W=3 instance for strobe length and latency.
module tb_sram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- W=1 instance with async SRAM model
    sram_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) b1 ();
    logic [2:0]  addr1;
    wire  [15:0] data1;
    logic        cs1, we1, oe1;
    logic [15:0] mem1 [8];

    sram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .sram_address(addr1), .sram_data(data1),
        .sram_cs(cs1), .sram_we(we1), .sram_oe(oe1)
    );
    assign data1 = (cs1 && oe1 && !we1) ? mem1[addr1] : 'z;
    always @(posedge clk) if (cs1 && we1) mem1[addr1] <= data1;

    // ---------------- W=3 instance
    sram_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) b3 ();
    logic [2:0]  addr3;
    wire  [15:0] data3;
    logic        cs3, we3, oe3;
    logic [15:0] mem3 [8];

    sram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(b3), .sram_address(addr3), .sram_data(data3),
        .sram_cs(cs3), .sram_we(we3), .sram_oe(oe3)
    );
    assign data3 = (cs3 && oe3 && !we3) ? mem3[addr3] : 'z;
    always @(posedge clk) if (cs3 && we3) mem3[addr3] <= data3;

    // ---------------- scoreboard for dut1 reads
    logic [15:0] shadow [8];
    logic [15:0] exp_q [$];
    int          acc_q [$];
    int          last_acc = 0;

    always @(negedge clk) begin
        if (b1.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'(1), 32'(0));
            end else begin
                logic [15:0] e;
                int t;
                e = exp_q.pop_front();
                t = acc_q.pop_front();
                check_eq("rsp_data", 32'(b1.rsp_rdata), 32'(e));
                check_eq("rsp_latency", 32'(cyc + 1 - t), 32'(3));
            end
        end
    end

    // ---------------- pin monitors: contention, strobe widths, address setup
    logic       p_we1 = 0, p_oe1 = 0, p_cs1 = 0, p_we3 = 0, p_oe3 = 0, p_cs3 = 0;
    logic [2:0] p_addr1 = 0, p_addr3 = 0;
    int         run_we1 = 0, run_oe1 = 0, run_we3 = 0, run_oe3 = 0;

    always @(negedge clk) begin
        check_eq("we_oe_excl1", 32'(we1 & oe1), 32'(0));
        check_eq("drive_oe_excl1", 32'(dut1.data_oe_q & oe1), 32'(0));
        check_eq("we_oe_excl3", 32'(we3 & oe3), 32'(0));
        check_eq("drive_oe_excl3", 32'(dut3.data_oe_q & oe3), 32'(0));
        if (we1 && !p_we1) begin
            check_eq("we1_addr_stable", 32'(addr1), 32'(p_addr1));
            check_eq("we1_setup_cs", 32'(p_cs1), 32'(1));
        end
        if (we3 && !p_we3) begin
            check_eq("we3_addr_stable", 32'(addr3), 32'(p_addr3));
            check_eq("we3_setup_cs", 32'(p_cs3), 32'(1));
        end
        if ((we1 || oe1) && !cs1) check_eq("cs1_in_strobe", 32'(cs1), 32'(1));
        if (p_we1 && !we1) begin
            check_eq("we1_width", 32'(run_we1), 32'(1));
            check_eq("cs1_in_hold", 32'(cs1), 32'(1));
        end
        if (p_oe1 && !oe1) check_eq("oe1_width", 32'(run_oe1), 32'(1));
        if (p_we3 && !we3) check_eq("we3_width", 32'(run_we3), 32'(3));
        if (p_oe3 && !oe3) check_eq("oe3_width", 32'(run_oe3), 32'(3));
        run_we1 = we1 ? run_we1 + 1 : 0;
        run_oe1 = oe1 ? run_oe1 + 1 : 0;
        run_we3 = we3 ? run_we3 + 1 : 0;
        run_oe3 = oe3 ? run_oe3 + 1 : 0;
        p_we1 = we1; p_oe1 = oe1; p_cs1 = cs1; p_addr1 = addr1;
        p_we3 = we3; p_oe3 = oe3; p_cs3 = cs3; p_addr3 = addr3;
    end

    // Drive a request on dut1 and return #1 after its accepting edge.
    task automatic do_req(input bit we, input logic [2:0] a, input logic [15:0] d,
                          input bit push, input bit gap);
        int n = 0;
        @(negedge clk);
        b1.req_valid = 1'b1;
        b1.req_we    = we;
        b1.req_addr  = a;
        b1.req_wdata = d;
        while (!b1.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check_eq("req_timeout", 32'(n), 32'(0));
            b1.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (gap) check_eq("accept_gap", 32'(cyc - last_acc), 32'(4));
        last_acc = cyc;
        if (we) shadow[a] = d;
        else if (push) begin
            exp_q.push_back(shadow[a]);
            acc_q.push_back(cyc);
        end
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        b1.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        for (int i = 0; i < 8; i++) begin
            mem1[i] = '0; mem3[i] = '0; shadow[i] = '0;
        end
        b1.req_valid = 0; b1.req_we = 0; b1.req_addr = 0; b1.req_wdata = 0;
        b3.req_valid = 0; b3.req_we = 0; b3.req_addr = 0; b3.req_wdata = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(b1.req_ready), 32'(0));
        check_eq("rst_strobes", 32'({cs1, we1, oe1}), 32'(0));
        check_eq("rst_bus", 32'(dut1.data_oe_q), 32'(0));
        check_eq("rst_addr", 32'(addr1), 32'(0));
        check_eq("rst_rsp_valid", 32'(b1.rsp_valid), 32'(0));
        check_eq("rst_rsp_rdata", 32'(b1.rsp_rdata), 32'(0));
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", 32'(b1.req_ready), 32'(1));

        // Write then read
        do_req(1'b1, 3'd5, 16'hA5C3, 1'b0, 1'b0);
        do_req(1'b0, 3'd5, 16'h0000, 1'b1, 1'b1);
        go_idle(6);

        // Full sweep, back-to-back
        for (int i = 0; i < 8; i++) do_req(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0, i != 0);
        for (int i = 7; i >= 0; i--) do_req(1'b0, 3'(i), 16'h0000, 1'b1, 1'b1);
        go_idle(6);

        // Requester keeps valid high with junk while the controller is busy
        do_req(1'b1, 3'd6, 16'h6666, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_eq("busy_not_ready", 32'(b1.req_ready), 32'(0));
            b1.req_valid = 1'b1;
            b1.req_we    = 1'b1;
            b1.req_addr  = 3'($urandom_range(0, 7));
            b1.req_wdata = 16'($urandom);
        end
        do_req(1'b0, 3'd6, 16'h0000, 1'b1, 1'b1);
        go_idle(6);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) go_idle(int'($urandom_range(0, 3)));
        end
        go_idle(8);

        // Reset during the strobe of a read at address 2
        do_req(1'b0, 3'd2, 16'h0000, 1'b0, 1'b0);
        b1.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_rst_in_strobe", 32'(oe1), 32'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_strobes", 32'({cs1, we1, oe1}), 32'(0));
        check_eq("mid_rst_bus", 32'(dut1.data_oe_q), 32'(0));
        check_eq("mid_rst_rsp_valid", 32'(b1.rsp_valid), 32'(0));
        check_eq("mid_rst_rdata", 32'(b1.rsp_rdata), 32'(0));
        check_eq("mid_rst_ready", 32'(b1.req_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(b1.req_ready), 32'(1));
        do_req(1'b0, 3'd3, 16'h0000, 1'b1, 1'b0);
        go_idle(6);

        // W=3: write then read
        @(negedge clk);
        b3.req_valid = 1'b1; b3.req_we = 1'b1; b3.req_addr = 3'd1; b3.req_wdata = 16'h5A5A;
        @(posedge clk);
        #1;
        t = cyc;
        b3.req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b3.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("w3_ready_return", 32'(cyc + 1 - t), 32'(6));
        b3.req_valid = 1'b1; b3.req_we = 1'b0; b3.req_addr = 3'd1;
        @(posedge clk);
        #1;
        t = cyc;
        b3.req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b3.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("w3_rsp_seen", 32'(b3.rsp_valid), 32'(1));
        check_eq("w3_read_latency", 32'(cyc + 1 - t), 32'(5));
        check_eq("w3_read_data", 32'(b3.rsp_rdata), 32'(16'h5A5A));
        @(negedge clk);
        check_eq("w3_rsp_pulse", 32'(b3.rsp_valid), 32'(0));
        check_eq("w3_rdata_hold", 32'(b3.rsp_rdata), 32'(16'h5A5A));

        // Drain the scoreboard
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("sb_drain", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
